// File: rtl/param_load_counter_if.sv
// rtl/param_load_counter_if.sv - control/data bundle between a driver and param_load_counter
interface param_load_counter_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic             enable;
  logic             up_dn;
  logic             clr_ovf;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] cout;
  logic             tc;
  logic             ovf;

  modport master (
    output load, enable, up_dn, clr_ovf, data,
    input  cout, tc, ovf
  );

  modport slave (
    input  load, enable, up_dn, clr_ovf, data,
    output cout, tc, ovf
  );
endinterface

// File: rtl/param_load_counter.sv
// rtl/param_load_counter.sv - loadable up/down counter with prescaler, wrap/saturate and sticky overflow
module param_load_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter bit               SATURATE  = 1'b0,
  parameter int               PRESCALE  = 1
) (
  input logic                  clk,
  input logic                  reset,
  param_load_counter_if.slave  bus
);
  localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] cout_q, cout_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             ovf_q, ovf_d;
  logic             at_bound;

  always_comb begin
    cout_d   = cout_q;
    ps_d     = ps_q;
    at_bound = 1'b0;
    if (bus.load) begin
      cout_d = (bus.data > MAX_COUNT) ? MAX_COUNT : bus.data;
      ps_d   = '0;
    end else if (bus.enable) begin
      if (ps_q == PS_LAST) begin
        ps_d = '0;
        // direction is only looked at on the step edge itself
        if (bus.up_dn) begin
          at_bound = (cout_q == MAX_COUNT);
          if (at_bound) cout_d = SATURATE ? MAX_COUNT : '0;
          else          cout_d = cout_q + WIDTH'(1);
        end else begin
          at_bound = (cout_q == '0);
          if (at_bound) cout_d = SATURATE ? '0 : MAX_COUNT;
          else          cout_d = cout_q - WIDTH'(1);
        end
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
    // a boundary step overrides a simultaneous clear
    ovf_d = (ovf_q & ~bus.clr_ovf) | at_bound;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cout_q <= '0;
      ps_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cout_q <= cout_d;
      ps_q   <= ps_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.tc   = bus.up_dn ? (cout_q == MAX_COUNT) : (cout_q == '0);
endmodule
